// File: rtl/shift_operand_stage.sv
// Operand-2 preparation stage ahead of the barrel shifter: maps imm/reg shift fields to shifter
// inputs, resolves out-of-range register amounts. Optional skid buffer via SHIFT_OPND_SKID_EN.
module shift_operand_stage #(
    parameter int TAG_W = 8
) (
    input  logic             in_Clk,
    input  logic             in_Rst,
    input  logic             in_Valid,
    output logic             out_Ready,
    input  logic             in_Flush,
    input  logic             in_Imm_op,
    input  logic [7:0]       in_Imm8,
    input  logic [3:0]       in_Rot,
    input  logic             in_Reg_shift,
    input  logic [1:0]       in_Shift_type,
    input  logic [4:0]       in_Shift_imm5,
    input  logic [31:0]      in_Rm_val,
    input  logic [31:0]      in_Rs_val,
    input  logic [TAG_W-1:0] in_Tag,
    output logic             out_Valid,
    input  logic             in_Ready,
    output logic [31:0]      out_Val,
    output logic [1:0]       out_Shift_type,
    output logic [4:0]       out_Shift_imm,
    output logic             out_Override,
    output logic [31:0]      out_Ovr_Op2,
    output logic             out_Ovr_Carry,
    output logic [TAG_W-1:0] out_Tag
);

    localparam logic [1:0] SH_LSL = 2'd0;
    localparam logic [1:0] SH_LSR = 2'd1;
    localparam logic [1:0] SH_ASR = 2'd2;
    localparam logic [1:0] SH_ROR = 2'd3;

    typedef struct packed {
        logic [31:0]      val;
        logic [1:0]       typ;
        logic [4:0]       amt;
        logic             ovr;
        logic [31:0]      op2;
        logic             carry;
        logic [TAG_W-1:0] tag;
    } bundle_t;

    bundle_t    map_d;
    logic [7:0] rs_amt;
    logic       unused_rs;

    assign rs_amt    = in_Rs_val[7:0];
    assign unused_rs = ^in_Rs_val[31:8];

    always_comb begin
        map_d     = '0;
        map_d.tag = in_Tag;
        map_d.typ = SH_LSL;
        if (in_Imm_op) begin
            map_d.val = {24'b0, in_Imm8};
            if (in_Rot != 4'd0) begin
                map_d.typ = SH_ROR;
                map_d.amt = {in_Rot, 1'b0};
            end
        end else if (!in_Reg_shift) begin
            map_d.val = in_Rm_val;
            map_d.typ = in_Shift_type;
            map_d.amt = in_Shift_imm5;
        end else begin
            map_d.val = in_Rm_val;
            if (rs_amt == 8'd0) begin
                map_d.typ = SH_LSL;
            end else if (rs_amt[7:5] == 3'b000) begin
                map_d.typ = in_Shift_type;
                map_d.amt = rs_amt[4:0];
            end else begin
                // Amounts >= 32: the 5-bit port cannot express these, so force or re-encode.
                case (in_Shift_type)
                    SH_LSL: begin
                        map_d.ovr   = 1'b1;
                        map_d.op2   = 32'd0;
                        map_d.carry = (rs_amt == 8'd32) ? in_Rm_val[0] : 1'b0;
                    end
                    SH_LSR: begin
                        if (rs_amt == 8'd32) begin
                            map_d.typ = SH_LSR;
                        end else begin
                            map_d.ovr   = 1'b1;
                            map_d.op2   = 32'd0;
                            map_d.carry = 1'b0;
                        end
                    end
                    SH_ASR: begin
                        map_d.typ = SH_ASR;
                    end
                    default: begin
                        if (rs_amt[4:0] == 5'd0) begin
                            map_d.ovr   = 1'b1;
                            map_d.op2   = in_Rm_val;
                            map_d.carry = in_Rm_val[31];
                        end else begin
                            map_d.typ = SH_ROR;
                            map_d.amt = rs_amt[4:0];
                        end
                    end
                endcase
            end
        end
    end

    logic    out_valid_q, out_valid_d;
    bundle_t out_q, out_d;
    logic    accept;
    logic    out_fire;

    assign accept   = in_Valid && out_Ready;
    assign out_fire = out_valid_q && in_Ready;

`ifdef SHIFT_OPND_SKID_EN
    logic    skid_valid_q, skid_valid_d;
    bundle_t skid_q, skid_d;

    // Ready depends only on skid occupancy, breaking the in_Ready -> out_Ready path.
    assign out_Ready = !skid_valid_q;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_d        = out_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
        if (in_Flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            if (out_fire) begin
                if (skid_valid_q) begin
                    out_d        = skid_q;
                    skid_valid_d = 1'b0;
                end else begin
                    out_valid_d = 1'b0;
                end
            end
            if (accept) begin
                if (!out_valid_q || out_fire) begin
                    out_valid_d = 1'b1;
                    out_d       = map_d;
                end else begin
                    skid_valid_d = 1'b1;
                    skid_d       = map_d;
                end
            end
        end
    end

    always_ff @(posedge in_Clk or posedge in_Rst) begin
        if (in_Rst) begin
            out_valid_q  <= 1'b0;
            out_q        <= '0;
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_q        <= out_d;
            skid_valid_q <= skid_valid_d;
            skid_q       <= skid_d;
        end
    end
`else
    assign out_Ready = !out_valid_q || in_Ready;

    always_comb begin
        out_valid_d = out_valid_q;
        out_d       = out_q;
        if (in_Flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            out_d       = map_d;
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge in_Clk or posedge in_Rst) begin
        if (in_Rst) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
        end
    end
`endif

    assign out_Valid      = out_valid_q;
    assign out_Val        = out_q.val;
    assign out_Shift_type = out_q.typ;
    assign out_Shift_imm  = out_q.amt;
    assign out_Override   = out_q.ovr;
    assign out_Ovr_Op2    = out_q.op2;
    assign out_Ovr_Carry  = out_q.carry;
    assign out_Tag        = out_q.tag;

endmodule

// File: tb/tb_shift_operand_stage.sv
// Scoreboard bench for shift_operand_stage: directed operand vectors, stall, flush and async reset.
module tb_shift_operand_stage;

    localparam logic [1:0] LSL = 2'd0;
    localparam logic [1:0] LSR = 2'd1;
    localparam logic [1:0] ASR = 2'd2;
    localparam logic [1:0] ROR = 2'd3;

    typedef struct packed {
        logic [31:0] val;
        logic [1:0]  typ;
        logic [4:0]  amt;
        logic        ovr;
        logic [31:0] op2;
        logic        c;
        logic [7:0]  tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        in_Rst = 1'b1;
    logic        in_Valid = 1'b0;
    logic        out_Ready;
    logic        in_Flush = 1'b0;
    logic        in_Imm_op = 1'b0;
    logic [7:0]  in_Imm8 = '0;
    logic [3:0]  in_Rot = '0;
    logic        in_Reg_shift = 1'b0;
    logic [1:0]  in_Shift_type = '0;
    logic [4:0]  in_Shift_imm5 = '0;
    logic [31:0] in_Rm_val = '0;
    logic [31:0] in_Rs_val = '0;
    logic [7:0]  in_Tag = '0;
    logic        out_Valid;
    logic        in_Ready = 1'b1;
    logic [31:0] out_Val;
    logic [1:0]  out_Shift_type;
    logic [4:0]  out_Shift_imm;
    logic        out_Override;
    logic [31:0] out_Ovr_Op2;
    logic        out_Ovr_Carry;
    logic [7:0]  out_Tag;

    int   errors = 0;
    int   checks = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    shift_operand_stage #(.TAG_W(8)) dut (
        .in_Clk(clk), .in_Rst(in_Rst), .in_Valid(in_Valid), .out_Ready(out_Ready),
        .in_Flush(in_Flush), .in_Imm_op(in_Imm_op), .in_Imm8(in_Imm8), .in_Rot(in_Rot),
        .in_Reg_shift(in_Reg_shift), .in_Shift_type(in_Shift_type),
        .in_Shift_imm5(in_Shift_imm5), .in_Rm_val(in_Rm_val), .in_Rs_val(in_Rs_val),
        .in_Tag(in_Tag), .out_Valid(out_Valid), .in_Ready(in_Ready), .out_Val(out_Val),
        .out_Shift_type(out_Shift_type), .out_Shift_imm(out_Shift_imm),
        .out_Override(out_Override), .out_Ovr_Op2(out_Ovr_Op2),
        .out_Ovr_Carry(out_Ovr_Carry), .out_Tag(out_Tag)
    );

    function automatic exp_t mk(logic [31:0] v, logic [1:0] t, logic [4:0] a, logic o,
                                logic [31:0] p, logic c, logic [7:0] g);
        exp_t e;
        e = '{val: v, typ: t, amt: a, ovr: o, op2: p, c: c, tag: g};
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the edge that accepted the bundle.
    task automatic send(input logic imm, input logic [7:0] imm8, input logic [3:0] rot,
                        input logic rsh, input logic [1:0] typ, input logic [4:0] imm5,
                        input logic [31:0] rm, input logic [31:0] rs, input logic [7:0] tag,
                        input exp_t e);
        int n;
        in_Imm_op = imm; in_Imm8 = imm8; in_Rot = rot; in_Reg_shift = rsh;
        in_Shift_type = typ; in_Shift_imm5 = imm5; in_Rm_val = rm; in_Rs_val = rs;
        in_Tag = tag; in_Valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (out_Ready) break;
            n++;
            if (n > 50) begin
                checks++; errors++;
                $display("FAIL send_timeout: tag %h never accepted", tag);
                break;
            end
        end
        if (n <= 50) sb_q.push_back(e);
        @(posedge clk); #1;
        in_Valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        in_Ready = 1'b1;
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk("drain_empty", sb_q.size(), 0);
        @(posedge clk); #1;
    endtask

    // Monitor: pops the scoreboard on every output transfer, checks hold during stalls.
    initial begin : monitor
        exp_t act, held, e;
        logic held_v;
        held_v = 1'b0;
        forever begin
            @(negedge clk);
            if (in_Rst) begin
                held_v = 1'b0;
            end else begin
                act = {out_Val, out_Shift_type, out_Shift_imm, out_Override, out_Ovr_Op2,
                       out_Ovr_Carry, out_Tag};
                if (held_v) begin
                    checks++;
                    if (act !== held || out_Valid !== 1'b1) begin
                        errors++;
                        $display("FAIL stall_hold: got %h valid %b expected %h valid 1",
                                 act, out_Valid, held);
                    end
                end
                held_v = 1'b0;
                if (out_Valid && !in_Ready && !in_Flush) begin
                    held_v = 1'b1;
                    held   = act;
                end
                if (out_Valid && in_Ready) begin
                    checks++;
                    if (sb_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_output: got %h expected nothing", act);
                    end else begin
                        e = sb_q.pop_front();
                        if (act !== e) begin
                            errors++;
                            $display("FAIL bundle_tag_%h: got %h expected %h", e.tag, act, e);
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", out_Valid, 0);
        chk("rst_val", out_Val, 0);
        chk("rst_override", out_Override, 0);
        chk("rst_op2", out_Ovr_Op2, 0);
        chk("rst_tag", out_Tag, 0);
        chk("rst_ready", out_Ready, 1);
        @(posedge clk); #1;
        in_Rst = 1'b0;
        @(posedge clk); #1;

        // Directed mapping vectors
        send(1, 8'hFF, 4'd4, 0, LSL, 5'd0, 32'hDEADBEEF, 32'd0, 8'h01,
             mk(32'hFF, ROR, 5'd8, 0, 0, 0, 8'h01));
        chk("latency_valid", out_Valid, 1);
        send(1, 8'h5A, 4'd0, 0, ROR, 5'd9, 32'h11111111, 32'd0, 8'h02,
             mk(32'h5A, LSL, 5'd0, 0, 0, 0, 8'h02));
        send(1, 8'h12, 4'hF, 1, LSR, 5'd0, 32'h22222222, 32'd40, 8'h03,
             mk(32'h12, ROR, 5'd30, 0, 0, 0, 8'h03));
        send(0, 8'h00, 4'd0, 0, ASR, 5'd17, 32'h12345678, 32'hFF, 8'h04,
             mk(32'h12345678, ASR, 5'd17, 0, 0, 0, 8'h04));
        send(0, 8'h00, 4'd0, 1, LSL, 5'd5, 32'h00000001, 32'd32, 8'h05,
             mk(32'h1, LSL, 5'd0, 1, 32'h0, 1, 8'h05));
        send(0, 8'h00, 4'd0, 1, LSL, 5'd5, 32'h00000001, 32'd33, 8'h06,
             mk(32'h1, LSL, 5'd0, 1, 32'h0, 0, 8'h06));
        send(0, 8'h00, 4'd0, 1, ROR, 5'd0, 32'h80000001, 32'd64, 8'h07,
             mk(32'h80000001, LSL, 5'd0, 1, 32'h80000001, 1, 8'h07));
        send(0, 8'h00, 4'd0, 1, ROR, 5'd0, 32'h80000001, 32'd35, 8'h08,
             mk(32'h80000001, ROR, 5'd3, 0, 0, 0, 8'h08));
        send(0, 8'h00, 4'd0, 1, ASR, 5'd0, 32'h80000000, 32'd200, 8'h09,
             mk(32'h80000000, ASR, 5'd0, 0, 0, 0, 8'h09));
        send(0, 8'h00, 4'd0, 1, LSR, 5'd0, 32'hF0000000, 32'd32, 8'h0A,
             mk(32'hF0000000, LSR, 5'd0, 0, 0, 0, 8'h0A));
        send(0, 8'h00, 4'd0, 1, LSR, 5'd0, 32'hF0000000, 32'd40, 8'h0B,
             mk(32'hF0000000, LSL, 5'd0, 1, 32'h0, 0, 8'h0B));
        send(0, 8'h00, 4'd0, 1, ASR, 5'd9, 32'h00000055, 32'h100, 8'h0C,
             mk(32'h55, LSL, 5'd0, 0, 0, 0, 8'h0C));
        send(0, 8'h00, 4'd0, 1, LSL, 5'd0, 32'h00000003, 32'd31, 8'h0D,
             mk(32'h3, LSL, 5'd31, 0, 0, 0, 8'h0D));
        send(0, 8'h00, 4'd0, 1, ROR, 5'd0, 32'h00000002, 32'hE0, 8'h0E,
             mk(32'h2, LSL, 5'd0, 1, 32'h2, 0, 8'h0E));
        send(0, 8'h00, 4'd0, 1, LSL, 5'd0, 32'hFFFFFFFE, 32'hFFFFFF20, 8'h0F,
             mk(32'hFFFFFFFE, LSL, 5'd0, 1, 32'h0, 0, 8'h0F));
        send(0, 8'h00, 4'd0, 1, LSR, 5'd0, 32'hCAFEF00D, 32'd1, 8'h10,
             mk(32'hCAFEF00D, LSR, 5'd1, 0, 0, 0, 8'h10));
        drain();

        // Stream of 4 with downstream stalled
        in_Ready = 1'b0;
        send(0, 8'h00, 4'd0, 0, LSL, 5'd1, 32'hA0000001, 32'd0, 8'h21,
             mk(32'hA0000001, LSL, 5'd1, 0, 0, 0, 8'h21));
`ifdef SHIFT_OPND_SKID_EN
        chk("ready_one_held", out_Ready, 1);
        send(0, 8'h00, 4'd0, 0, LSR, 5'd2, 32'hA0000002, 32'd0, 8'h22,
             mk(32'hA0000002, LSR, 5'd2, 0, 0, 0, 8'h22));
        chk("ready_two_held", out_Ready, 0);
`else
        chk("ready_one_held", out_Ready, 0);
`endif
        fork
            begin
                repeat (2) @(posedge clk);
                #1 in_Ready = 1'b1;
            end
            begin
`ifndef SHIFT_OPND_SKID_EN
                send(0, 8'h00, 4'd0, 0, LSR, 5'd2, 32'hA0000002, 32'd0, 8'h22,
                     mk(32'hA0000002, LSR, 5'd2, 0, 0, 0, 8'h22));
`endif
                send(0, 8'h00, 4'd0, 0, ASR, 5'd3, 32'hA0000003, 32'd0, 8'h23,
                     mk(32'hA0000003, ASR, 5'd3, 0, 0, 0, 8'h23));
                send(0, 8'h00, 4'd0, 0, ROR, 5'd4, 32'hA0000004, 32'd0, 8'h24,
                     mk(32'hA0000004, ROR, 5'd4, 0, 0, 0, 8'h24));
            end
        join
        drain();

        // Flush coinciding with an accept while output is valid and being consumed
        send(0, 8'h00, 4'd0, 0, LSL, 5'd6, 32'h0000A1A1, 32'd0, 8'h31,
             mk(32'h0000A1A1, LSL, 5'd6, 0, 0, 0, 8'h31));
        in_Tag = 8'hEE; in_Rm_val = 32'hBADBAD00; in_Valid = 1'b1; in_Flush = 1'b1;
        @(posedge clk); #1;
        in_Valid = 1'b0; in_Flush = 1'b0;
        chk("flush_accept_valid", out_Valid, 0);
        repeat (3) @(posedge clk); #1;

        // Flush discarding held bundles under stall
        in_Ready = 1'b0;
        send(0, 8'h00, 4'd0, 0, LSR, 5'd7, 32'h0000B2B2, 32'd0, 8'h41,
             mk(32'h0000B2B2, LSR, 5'd7, 0, 0, 0, 8'h41));
`ifdef SHIFT_OPND_SKID_EN
        send(0, 8'h00, 4'd0, 0, LSR, 5'd8, 32'h0000B3B3, 32'd0, 8'h42,
             mk(32'h0000B3B3, LSR, 5'd8, 0, 0, 0, 8'h42));
`endif
        in_Flush = 1'b1;
        sb_q.delete();
        @(posedge clk); #1;
        in_Flush = 1'b0;
        chk("flush_held_valid", out_Valid, 0);
        chk("flush_held_ready", out_Ready, 1);
        in_Ready = 1'b1;
        repeat (3) @(posedge clk); #1;

        // Asynchronous reset in the middle of a cycle
        in_Ready = 1'b0;
        send(0, 8'h00, 4'd0, 0, ASR, 5'd9, 32'h0000C3C3, 32'd0, 8'h51,
             mk(32'h0000C3C3, ASR, 5'd9, 0, 0, 0, 8'h51));
        #2 in_Rst = 1'b1;
        #1;
        chk("async_rst_valid", out_Valid, 0);
        chk("async_rst_val", out_Val, 0);
        chk("async_rst_tag", out_Tag, 0);
        sb_q.delete();
        @(posedge clk); #1;
        in_Rst = 1'b0;
        in_Ready = 1'b1;

        send(0, 8'h00, 4'd0, 1, LSL, 5'd0, 32'h00000001, 32'd4, 8'h61,
             mk(32'h1, LSL, 5'd4, 0, 0, 0, 8'h61));
        drain();
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
